// File: rtl/updown_counter_reg_pkg.sv
// rtl/updown_counter_reg_pkg.sv - shared constants and step kinds for the up/down counter
package updown_counter_reg_pkg;

    // Default counter width; the counter supports any width of 2 or more.
    localparam int DEFAULT_WIDTH = 4;

    // Limits of an unsigned counter at the default width.
    localparam logic [DEFAULT_WIDTH-1:0] CNT_MAX  = {DEFAULT_WIDTH{1'b1}};
    localparam logic [DEFAULT_WIDTH-1:0] CNT_ZERO = {DEFAULT_WIDTH{1'b0}};

    // What the state register does on a given edge, in priority order LOAD > INC/DEC > HOLD.
    typedef enum logic [1:0] {
        HOLD = 2'd0,
        LOAD = 2'd1,
        INC  = 2'd2,
        DEC  = 2'd3
    } step_t;

endpackage

// File: rtl/inc_dec_core.sv
// rtl/inc_dec_core.sv - ripple incrementer/decrementer with carry/borrow out
module inc_dec_core #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic             up,
    output logic [WIDTH-1:0] y,
    output logic             co
);

    // Ripple chain: a bit toggles while every lower bit is 1 (increment) or 0 (decrement).
    // The final ripple is the carry (increment at all-ones) or borrow (decrement at zero).
    logic [WIDTH:0] chain;

    // Bitwise ripple of the +1 / -1 step.
    always_comb begin
        chain    = '0;
        y        = '0;
        chain[0] = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            y[i]         = a[i] ^ chain[i];
            chain[i + 1] = (up ? a[i] : ~a[i]) & chain[i];
        end
    end

    assign co = chain[WIDTH];

endmodule

// File: rtl/updown_counter_reg.sv
// rtl/updown_counter_reg.sv - registered up/down counter with load, saturate, carry pulse and sticky flags
module updown_counter_reg
    import updown_counter_reg_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int RESET_VALUE = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             UP,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    input  logic             SAT,
    input  logic             CLR_FLAGS,
    output logic [WIDTH-1:0] Q,
    output logic             COUT,
    output logic             ZERO,
    output logic             OVF,
    output logic             UNF
);

    localparam logic [WIDTH-1:0] Q_RESET = WIDTH'(RESET_VALUE);

    step_t            step;
    logic [WIDTH-1:0] q_q, q_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] core_y;
    logic             core_co;
    logic             hit_max;
    logic             hit_min;

    // The datapath always sees the current count; UP only matters when a step is taken.
    inc_dec_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a (q_q),
        .up(UP),
        .y (core_y),
        .co(core_co)
    );

    // Decode the edge's action with load taking priority over counting.
    always_comb begin
        step = HOLD;
        if (LD) begin
            step = LOAD;
        end else if (EN) begin
            step = UP ? INC : DEC;
        end
    end

    // Boundary events: the ripple ran off the end in the direction being stepped.
    always_comb begin
        hit_max = (step == INC) && core_co;
        hit_min = (step == DEC) && core_co;
    end

    // Next count, carry pulse and sticky flags; a flag set on this edge beats a clear.
    always_comb begin
        q_d    = q_q;
        cout_d = 1'b0;
        case (step)
            LOAD: q_d = D;
            INC,
            DEC: begin
                cout_d = core_co;
                q_d    = (core_co && SAT) ? q_q : core_y;
            end
            default: q_d = q_q;
        endcase
        ovf_d = (ovf_q && !CLR_FLAGS) || hit_max;
        unf_d = (unf_q && !CLR_FLAGS) || hit_min;
    end

    // State register with asynchronous reset to the configured start value.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q_q    <= Q_RESET;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    assign Q    = q_q;
    assign COUT = cout_q;
    assign OVF  = ovf_q;
    assign UNF  = unf_q;
    assign ZERO = (q_q == '0);

endmodule
